// File: rtl/btn_pkg.sv
// btn_pkg: timing defaults, repeat FSM encoding and width helper for the button conditioner.
package btn_pkg;
  localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
  localparam int REPEAT_DELAY_500MS   = 50_000_000;
  localparam int REPEAT_PERIOD_100MS  = 10_000_000;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rpt_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel of sync, debounce and edge pulses; BTN_AUTO_REPEAT_EN adds the auto-repeat FSM.
module btn_debounce_ch
  import btn_pkg::*;
#(
`ifdef BTN_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
`endif
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic step_o
);
  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, level_q, rise_q, fall_q;
  logic flip, rise_d, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip   = s2_q != level_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    rise_d = flip & ~level_q;
    fall_d = flip & level_q;
    cnt_d  = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_q ^ flip;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  rpt_state_e st_q;
  logic [RW-1:0] rcnt_q;
  logic step_q, rep;
  assign rep = (st_q == DELAY && rcnt_q == RW'(REPEAT_DELAY - 1)) ||
               (st_q == REPEAT && rcnt_q == RW'(REPEAT_PERIOD - 1));
  // a release overrides any repeat tick that lands on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q   <= IDLE;
      rcnt_q <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= rise_d | (rep & ~fall_d);
      if (fall_d) begin
        st_q   <= IDLE;
        rcnt_q <= '0;
      end else if (rise_d) begin
        st_q   <= DELAY;
        rcnt_q <= '0;
      end else if (rep) begin
        st_q   <= REPEAT;
        rcnt_q <= '0;
      end else if (st_q != IDLE) rcnt_q <= rcnt_q + 1'b1;
    end
  assign step_o = step_q;
`else
  assign step_o = rise_q;
`endif
endmodule

// File: rtl/btn_debounce_step.sv
// btn_debounce_step: N-channel button conditioner with a registered any-pressed flag; BTN_AUTO_REPEAT_EN enables auto-repeat steps.
module btn_debounce_step
  import btn_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic         clk,
  input  logic         RST,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_rise,
  output logic [N-1:0] btn_fall,
  output logic [N-1:0] btn_step,
  output logic         any_level
);
  logic any_q;
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce_step: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_debounce_ch #(
`ifdef BTN_AUTO_REPEAT_EN
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(RST),
      .btn_i(btn_in[i]),
      .level_o(btn_level[i]),
      .rise_o(btn_rise[i]),
      .fall_o(btn_fall[i]),
      .step_o(btn_step[i])
    );
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) any_q <= 1'b0;
    else any_q <= |btn_level;
  assign any_level = any_q;
endmodule

// File: tb/tb_btn_debounce_step.sv
// tb_btn_debounce_step: directed tables and sequences plus randomized run against a hold-time reference model.
module tb_btn_debounce_step;
  localparam int N = 4, D = 4, RD = 10, RP = 5;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, RST = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_rise, btn_fall, btn_step;
  logic any_level;
  int n_cmp = 0, n_bad = 0, ecnt = 0;
  always #5 clk = ~clk;
  btn_debounce_step #(.N(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .RST(RST), .btn_in(btn_in), .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .btn_step(btn_step), .any_level(any_level)
  );
  logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_step = '0, d1 = '0, d2 = '0;
  logic m_any = 1'b0;
  int run[N], held[N];
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_step = '0; m_any = 1'b0;
      d1 = '0; d2 = '0; ecnt = 0;
      for (int c = 0; c < N; c++) begin run[c] = 0; held[c] = 0; end
    end else begin
      ecnt++;
      m_any = |m_level;
      for (int c = 0; c < N; c++) begin
        m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_step[c] = 1'b0;
        run[c] = (d2[c] != m_level[c]) ? run[c] + 1 : 0;
        if (run[c] == D) begin
          m_level[c] = ~m_level[c];
          m_rise[c] = m_level[c];
          m_fall[c] = ~m_level[c];
          run[c] = 0;
          held[c] = 0;
        end else if (m_level[c]) held[c]++;
        if (m_level[c])
          m_step[c] = AUTO ? (held[c] == 0 || (held[c] >= RD && (held[c] - RD) % RP == 0)) : m_rise[c];
      end
      d2 = d1;
      d1 = btn_in;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, ecnt, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("model", {btn_level, btn_rise, btn_fall, btn_step, any_level},
        {m_level, m_rise, m_fall, m_step, m_any});
  endtask
  typedef struct {
    logic [N-1:0] btn, lvl, rise, fall;
    logic any;
  } vec_t;
  vec_t tbl[18];
  initial begin
    for (int e = 1; e <= 18; e++)
      tbl[e-1] = '{btn: (e >= 10) ? 4'b0001 : 4'b0000, lvl: (e >= 15) ? 4'b0001 : 4'b0000,
                   rise: (e == 15) ? 4'b0001 : 4'b0000, fall: 4'b0000, any: e >= 16};
    cyc();
    chk("reset_hold", {btn_level, btn_rise, btn_fall, btn_step, any_level}, '0);
    RST = 1'b0;
    for (int i = 0; i < 18; i++) begin
      btn_in = tbl[i].btn;
      cyc();
      chk("press_tbl", {btn_level, btn_rise, btn_fall, btn_step, any_level},
          {tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].rise, tbl[i].any});
    end
    for (int e = 19; e <= 55; e++) begin
      btn_in[1] = (e >= 19 && e <= 21) || (e >= 24 && e <= 26);
      btn_in[0] = e <= 40;
      cyc();
      chk("bounce_ch1", {btn_level[1], btn_rise[1], btn_fall[1], btn_step[1]}, 4'b0000);
      chk("repeat_ch0", {btn_level[0], btn_step[0], btn_fall[0]},
          {e < 46, AUTO && e >= 25 && e <= 45 && (e - 25) % 5 == 0, e == 46});
    end
    for (int e = 56; e <= 78; e++) begin
      btn_in = (e <= 70) ? 4'b1100 : 4'b0000;
      cyc();
      if (e >= 71)
        chk("release_23", {btn_level[3:2], btn_fall[3:2], any_level},
            {(e < 76) ? 2'b11 : 2'b00, (e == 76) ? 2'b11 : 2'b00, e < 77});
    end
    btn_in = 4'b0001;
    cyc();
    cyc();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("in_reset", {btn_level, btn_rise, btn_fall, btn_step, any_level}, '0);
    end
    RST = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk("post_reset", {btn_level[0], btn_rise[0], btn_step[0], any_level},
          {e >= 6, e == 6, e == 6, e >= 7});
    end
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, (i < 2000) ? 2 : 11) == 0) btn_in[$urandom_range(0, N-1)] ^= 1'b1;
      RST = ($urandom_range(0, 599) == 0);
      cyc();
    end
    RST = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
